regfile_scoreboard: RTL and testbench

Parametrised successor to the pipeline's 16x32 register file. It provides a general-purpose register array with configurable width and depth, two combinational read ports with optional write-to-read bypass, and an optional hardwired zero register. It adds a per-register pending-write scoreboard, so the decode stage can detect RAW and WAW hazards and stall. It sits between decode, which issues destinations and reads operands, and writeback, which commits results.

---
 rtl/regfile_scoreboard.sv | 103 ++++++++++
 tb/tb_regfile_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, optional bypass and zero register,
// plus a per-register pending-write scoreboard for RAW/WAW hazard detection.
module regfile_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned ZERO_REG = 0,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_ws,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [ADDR_W-1:0] i_rs1,
   input  logic [ADDR_W-1:0] i_rs2,
   input  logic              i_use1,
   input  logic              i_use2,
   input  logic              i_issue,
   input  logic [ADDR_W-1:0] i_issue_rd,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2,
   output logic              o_busy1,
   output logic              o_busy2,
   output logic              o_stall,
   output logic [ADDR_W:0]   o_pending,
   output logic              o_err
);

   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [NREGS-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   pending_q, pending_d;
   logic              err_q, err_d;

   logic zero1, zero2, zero_ws, zero_issue;
   logic byp1, byp2, waw, stall;

   always_comb begin
      zero1      = (ZERO_REG != 0) && (i_rs1 == '0);
      zero2      = (ZERO_REG != 0) && (i_rs2 == '0);
      zero_ws    = (ZERO_REG != 0) && (i_ws == '0);
      zero_issue = (ZERO_REG != 0) && (i_issue_rd == '0);
      byp1       = (BYPASS != 0) && i_we && (i_ws == i_rs1);
      byp2       = (BYPASS != 0) && i_we && (i_ws == i_rs2);

      o_rd1 = zero1 ? '0 : (byp1 ? i_wd : regs_q[i_rs1]);
      o_rd2 = zero2 ? '0 : (byp2 ? i_wd : regs_q[i_rs2]);

      o_busy1 = !zero1 && busy_q[i_rs1] && !byp1;
      o_busy2 = !zero2 && busy_q[i_rs2] && !byp2;

      // WAW: a same-cycle writeback of the destination retires the older write regardless of BYPASS
      waw = i_issue && !zero_issue && busy_q[i_issue_rd] && !(i_we && (i_ws == i_issue_rd));

      stall   = (i_use1 && o_busy1) || (i_use2 && o_busy2) || waw;
      o_stall = stall;
   end

   always_comb begin
      busy_d = busy_q;
      if (i_we) begin
         busy_d[i_ws] = 1'b0;
      end
      // Set after clear so a retiring older write never hides a newly issued one
      if (i_issue && !stall && !zero_issue) begin
         busy_d[i_issue_rd] = 1'b1;
      end

      pending_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         pending_d = pending_d + (ADDR_W+1)'(busy_d[i]);
      end

      err_d = err_q || (i_issue && stall);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_we && !zero_ws) begin
         regs_q[i_ws] <= i_wd;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         busy_q    <= '0;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign o_pending = pending_q;
   assign o_err     = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: instance a uses defaults (BYPASS=1, ZERO_REG=0); instance b uses BYPASS=0, ZERO_REG=1.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        a_we, a_use1, a_use2, a_issue;
   logic [3:0]  a_ws, a_rs1, a_rs2, a_ird;
   logic [31:0] a_wd, a_rd1, a_rd2;
   logic        a_busy1, a_busy2, a_stall, a_err;
   logic [4:0]  a_pend;

   logic        b_we, b_use1, b_use2, b_issue;
   logic [3:0]  b_ws, b_rs1, b_rs2, b_ird;
   logic [31:0] b_wd, b_rd1, b_rd2;
   logic        b_busy1, b_busy2, b_stall, b_err;
   logic [4:0]  b_pend;

   regfile_scoreboard u_dut_a (
      .i_clk(clk), .i_reset_n(reset_n), .i_we(a_we), .i_ws(a_ws), .i_wd(a_wd),
      .i_rs1(a_rs1), .i_rs2(a_rs2), .i_use1(a_use1), .i_use2(a_use2),
      .i_issue(a_issue), .i_issue_rd(a_ird), .o_rd1(a_rd1), .o_rd2(a_rd2),
      .o_busy1(a_busy1), .o_busy2(a_busy2), .o_stall(a_stall), .o_pending(a_pend), .o_err(a_err)
   );

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
      .i_clk(clk), .i_reset_n(reset_n), .i_we(b_we), .i_ws(b_ws), .i_wd(b_wd),
      .i_rs1(b_rs1), .i_rs2(b_rs2), .i_use1(b_use1), .i_use2(b_use2),
      .i_issue(b_issue), .i_issue_rd(b_ird), .o_rd1(b_rd1), .o_rd2(b_rd2),
      .o_busy1(b_busy1), .o_busy2(b_busy2), .o_stall(b_stall), .o_pending(b_pend), .o_err(b_err)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_we = 0; a_ws = 0; a_wd = 0; a_rs1 = 0; a_rs2 = 0;
      a_use1 = 0; a_use2 = 0; a_issue = 0; a_ird = 0;
   endtask

   task automatic idle_b();
      b_we = 0; b_ws = 0; b_wd = 0; b_rs1 = 0; b_rs2 = 0;
      b_use1 = 0; b_use2 = 0; b_issue = 0; b_ird = 0;
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  ws;
      logic [31:0] wd;
      logic [3:0]  rs1, rs2;
      logic        use1, use2, issue;
      logic [3:0]  ird;
      logic [31:0] e_rd1, e_rd2;
      logic        e_b1, e_b2, e_stall;
      logic [4:0]  e_pend;
   } vec_t;

   vec_t vt[10];

   initial begin
      // we ws wd rs1 rs2 use1 use2 issue ird | rd1 rd2 busy1 busy2 stall pending-after-edge
      vt[0] = '{1, 1, 32'h11111111, 1, 2, 0, 0, 0, 0, 32'h11111111, 32'h0,        0, 0, 0, 0};
      vt[1] = '{1, 2, 32'h22222222, 1, 2, 0, 0, 0, 0, 32'h11111111, 32'h22222222, 0, 0, 0, 0};
      vt[2] = '{0, 0, 32'h0,        2, 1, 1, 1, 1, 4, 32'h22222222, 32'h11111111, 0, 0, 0, 1};
      vt[3] = '{0, 0, 32'h0,        4, 1, 0, 1, 1, 5, 32'h0,        32'h11111111, 1, 0, 0, 2};
      vt[4] = '{0, 0, 32'h0,        4, 1, 1, 0, 0, 0, 32'h0,        32'h11111111, 1, 0, 1, 2};
      vt[5] = '{1, 4, 32'h44444444, 4, 5, 1, 0, 0, 0, 32'h44444444, 32'h0,        0, 1, 0, 1};
      vt[6] = '{0, 0, 32'h0,        4, 5, 0, 1, 0, 0, 32'h44444444, 32'h0,        0, 1, 1, 1};
      vt[7] = '{1, 5, 32'h55555555, 5, 4, 1, 0, 1, 5, 32'h55555555, 32'h44444444, 0, 0, 0, 1};
      vt[8] = '{0, 0, 32'h0,        5, 0, 0, 0, 0, 0, 32'h55555555, 32'h0,        1, 0, 0, 1};
      vt[9] = '{1, 5, 32'hAAAA5555, 5, 0, 1, 0, 0, 0, 32'hAAAA5555, 32'h0,        0, 0, 0, 0};

      idle_a();
      idle_b();
      reset_n = 0;
      #2;
      chk("reset_rd1", a_rd1, 0);
      chk("reset_pend", {27'b0, a_pend}, 0);
      chk("reset_stall", {31'b0, a_stall}, 0);
      #10 reset_n = 1;
      tick();

      for (int i = 0; i < 10; i++) begin
         a_we = vt[i].we; a_ws = vt[i].ws; a_wd = vt[i].wd;
         a_rs1 = vt[i].rs1; a_rs2 = vt[i].rs2; a_use1 = vt[i].use1; a_use2 = vt[i].use2;
         a_issue = vt[i].issue; a_ird = vt[i].ird;
         #1;
         chk($sformatf("vec%0d_rd1", i), a_rd1, vt[i].e_rd1);
         chk($sformatf("vec%0d_rd2", i), a_rd2, vt[i].e_rd2);
         chk($sformatf("vec%0d_busy1", i), {31'b0, a_busy1}, {31'b0, vt[i].e_b1});
         chk($sformatf("vec%0d_busy2", i), {31'b0, a_busy2}, {31'b0, vt[i].e_b2});
         chk($sformatf("vec%0d_stall", i), {31'b0, a_stall}, {31'b0, vt[i].e_stall});
         tick();
         chk($sformatf("vec%0d_pend", i), {27'b0, a_pend}, {27'b0, vt[i].e_pend});
      end
      idle_a();

      // RAW on r3 with bypass: stall until the writeback cycle, which itself is stall-free
      a_issue = 1; a_ird = 3;
      tick();
      chk("raw_pend_set", {27'b0, a_pend}, 1);
      a_issue = 0; a_rs2 = 3; a_use2 = 1;
      #1;
      chk("raw_stall_c1", {31'b0, a_stall}, 1);
      tick();
      chk("raw_stall_c2", {31'b0, a_stall}, 1);
      a_we = 1; a_ws = 3; a_wd = 32'h33333333;
      #1;
      chk("raw_stall_wb", {31'b0, a_stall}, 0);
      chk("raw_rd2_wb", a_rd2, 32'h33333333);
      tick();
      chk("raw_pend_clr", {27'b0, a_pend}, 0);
      idle_a();

      // Issue r2 twice; second issue is forced through the WAW stall
      a_issue = 1; a_ird = 2;
      tick();
      a_issue = 1; a_ird = 2;
      #1;
      chk("err_stall", {31'b0, a_stall}, 1);
      tick();
      chk("err_set", {31'b0, a_err}, 1);
      chk("err_pend", {27'b0, a_pend}, 1);
      idle_a();
      tick();
      chk("err_sticky", {31'b0, a_err}, 1);
      a_we = 1; a_ws = 2; a_wd = 32'h22220000;
      tick();
      idle_a();
      chk("err_after_wb", {31'b0, a_err}, 1);
      chk("err_wb_pend", {27'b0, a_pend}, 0);

      // Instance b: no bypass, old data in the write cycle
      b_we = 1; b_ws = 5; b_wd = 32'hDEADBEEF; b_rs1 = 5;
      #1;
      chk("b_nobyp_old", b_rd1, 0);
      tick();
      b_we = 0;
      #1;
      chk("b_nobyp_new", b_rd1, 32'hDEADBEEF);

      // Zero register: write and issue of r0 are ignored
      b_we = 1; b_ws = 0; b_wd = 32'h1234; b_issue = 1; b_ird = 0; b_rs1 = 0; b_use1 = 1;
      #1;
      chk("b_zero_rd1", b_rd1, 0);
      chk("b_zero_busy", {31'b0, b_busy1}, 0);
      chk("b_zero_stall", {31'b0, b_stall}, 0);
      tick();
      chk("b_zero_pend", {27'b0, b_pend}, 0);
      idle_b();
      b_use1 = 1;
      #1;
      chk("b_zero_rd1_after", b_rd1, 0);
      chk("b_zero_busy_after", {31'b0, b_busy1}, 0);
      idle_b();

      // RAW without bypass: hazard persists through the writeback cycle
      b_issue = 1; b_ird = 3;
      tick();
      chk("b_raw_pend", {27'b0, b_pend}, 1);
      b_issue = 0; b_rs2 = 3; b_use2 = 1;
      #1;
      chk("b_raw_stall", {31'b0, b_stall}, 1);
      tick();
      b_we = 1; b_ws = 3; b_wd = 32'h0BADF00D;
      #1;
      chk("b_raw_stall_wb", {31'b0, b_stall}, 1);
      chk("b_raw_rd2_wb", b_rd2, 0);
      tick();
      chk("b_raw_pend_clr", {27'b0, b_pend}, 0);
      b_we = 0;
      #1;
      chk("b_raw_stall_after", {31'b0, b_stall}, 0);
      chk("b_raw_rd2_after", b_rd2, 32'h0BADF00D);
      idle_b();
      b_issue = 1; b_ird = 9;
      a_issue = 1; a_ird = 7;
      tick();
      idle_a();
      idle_b();
      chk("pre_reset_pend_a", {27'b0, a_pend}, 1);
      chk("pre_reset_pend_b", {27'b0, b_pend}, 1);

      // Asynchronous reset mid-cycle
      reset_n = 0;
      #1;
      for (int s = 0; s < 16; s++) begin
         a_rs1 = 4'(s);
         #1;
         chk($sformatf("rst_rd1_r%0d", s), a_rd1, 0);
      end
      chk("rst_pend_a", {27'b0, a_pend}, 0);
      chk("rst_err_a", {31'b0, a_err}, 0);
      chk("rst_pend_b", {27'b0, b_pend}, 0);
      b_rs1 = 5;
      #1;
      chk("rst_rd1_b", b_rd1, 0);
      a_rs1 = 7;
      #1;
      chk("rst_busy_a", {31'b0, a_busy1}, 0);
      @(negedge clk);
      reset_n = 1;
      idle_a();
      idle_b();

      // First edge after deassert performs normal updates
      a_we = 1; a_ws = 6; a_wd = 32'hCAFEF00D; a_issue = 1; a_ird = 8;
      tick();
      idle_a();
      a_rs1 = 6;
      #1;
      chk("post_rst_rd1", a_rd1, 32'hCAFEF00D);
      chk("post_rst_pend", {27'b0, a_pend}, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
